// File: rtl/decoder_pipe.sv
// RV32I (+ optional RV32M) instruction decoder followed by a 2-entry skid buffer.
// Latency: one cycle. An instruction accepted at edge k is presented in the cycle after k.
// Backpressure: in_ready drops while both entries are full; the head entry holds steady while out_ready is low.
//
// Ports:
//   clk, rst_n           clock, async active-low reset (empties buffer, zeroes outputs)
//   in_valid/in_ready    upstream handshake; instr + pc_in sampled on accept
//   flush                discards all buffered entries, wins over same-edge accept/pop
//   out_valid/out_ready  downstream handshake
//   pc_out, rd, rs1, rs2, *_valid, imm, op, illegal
//                        decoded fields of the head entry, driven straight from flops
module decoder_pipe #(
   parameter int XLEN = 32,
   parameter int EN_M = 0,
   localparam int OPW = 37 + 8 * EN_M
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     instr,
   input  logic [XLEN-1:0] pc_in,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] pc_out,
   output logic [4:0]      rd,
   output logic [4:0]      rs1,
   output logic [4:0]      rs2,
   output logic            rd_valid,
   output logic            rs1_valid,
   output logic            rs2_valid,
   output logic            imm_valid,
   output logic [XLEN-1:0] imm,
   output logic [OPW-1:0]  op,
   output logic            illegal
);

   // Operation indices into the one-hot op bus.
   localparam logic [5:0] OP_ADD   = 6'd0;
   localparam logic [5:0] OP_SUB   = 6'd1;
   localparam logic [5:0] OP_XOR   = 6'd2;
   localparam logic [5:0] OP_OR    = 6'd3;
   localparam logic [5:0] OP_AND   = 6'd4;
   localparam logic [5:0] OP_SLL   = 6'd5;
   localparam logic [5:0] OP_SRL   = 6'd6;
   localparam logic [5:0] OP_SRA   = 6'd7;
   localparam logic [5:0] OP_SLT   = 6'd8;
   localparam logic [5:0] OP_SLTU  = 6'd9;
   localparam logic [5:0] OP_ADDI  = 6'd10;
   localparam logic [5:0] OP_XORI  = 6'd11;
   localparam logic [5:0] OP_ORI   = 6'd12;
   localparam logic [5:0] OP_ANDI  = 6'd13;
   localparam logic [5:0] OP_SLLI  = 6'd14;
   localparam logic [5:0] OP_SRLI  = 6'd15;
   localparam logic [5:0] OP_SRAI  = 6'd16;
   localparam logic [5:0] OP_SLTI  = 6'd17;
   localparam logic [5:0] OP_SLTIU = 6'd18;
   localparam logic [5:0] OP_LB    = 6'd19;
   localparam logic [5:0] OP_LH    = 6'd20;
   localparam logic [5:0] OP_LW    = 6'd21;
   localparam logic [5:0] OP_LBU   = 6'd22;
   localparam logic [5:0] OP_LHU   = 6'd23;
   localparam logic [5:0] OP_SB    = 6'd24;
   localparam logic [5:0] OP_SH    = 6'd25;
   localparam logic [5:0] OP_SW    = 6'd26;
   localparam logic [5:0] OP_BEQ   = 6'd27;
   localparam logic [5:0] OP_BNE   = 6'd28;
   localparam logic [5:0] OP_BLT   = 6'd29;
   localparam logic [5:0] OP_BGE   = 6'd30;
   localparam logic [5:0] OP_BLTU  = 6'd31;
   localparam logic [5:0] OP_BGEU  = 6'd32;
   localparam logic [5:0] OP_JAL   = 6'd33;
   localparam logic [5:0] OP_JALR  = 6'd34;
   localparam logic [5:0] OP_LUI   = 6'd35;
   localparam logic [5:0] OP_AUIPC = 6'd36;
   localparam logic [5:0] OP_MUL   = 6'd37;   // mul..remu follow in funct3 order
   localparam logic [5:0] OP_NONE  = 6'd63;

   localparam logic [5:0]     OPW6   = 6'(OPW);
   localparam logic [OPW-1:0] OP_ONE = {{(OPW-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      FMT_R,
      FMT_I,
      FMT_S,
      FMT_B,
      FMT_U,
      FMT_J
   } fmt_t;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [4:0]      rd;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic            rd_valid;
      logic            rs1_valid;
      logic            rs2_valid;
      logic            imm_valid;
      logic [XLEN-1:0] imm;
      logic [OPW-1:0]  op;
      logic            illegal;
   } entry_t;

   logic [6:0]  w_opc;
   logic [2:0]  w_f3;
   logic [6:0]  w_f7;
   logic [5:0]  w_opidx;
   fmt_t        w_fmt;
   logic        w_legal;
   logic [31:0] w_imm32;
   entry_t      w_dec;

   assign w_opc = instr[6:0];
   assign w_f3  = instr[14:12];
   assign w_f7  = instr[31:25];

   // Operation select: anything that falls through leaves OP_NONE, which is
   // what makes an encoding illegal.
   always_comb begin
      w_opidx = OP_NONE;
      w_fmt   = FMT_R;
      case (w_opc)
         7'b0110011: begin
            w_fmt = FMT_R;
            case (w_f7)
               7'h00: begin
                  case (w_f3)
                     3'd0:    w_opidx = OP_ADD;
                     3'd1:    w_opidx = OP_SLL;
                     3'd2:    w_opidx = OP_SLT;
                     3'd3:    w_opidx = OP_SLTU;
                     3'd4:    w_opidx = OP_XOR;
                     3'd5:    w_opidx = OP_SRL;
                     3'd6:    w_opidx = OP_OR;
                     default: w_opidx = OP_AND;
                  endcase
               end
               7'h20: begin
                  if (w_f3 == 3'd0) w_opidx = OP_SUB;
                  else if (w_f3 == 3'd5) w_opidx = OP_SRA;
               end
               7'h01: begin
                  if (EN_M != 0) w_opidx = OP_MUL + {3'b000, w_f3};
               end
               default: ;
            endcase
         end
         7'b0010011: begin
            w_fmt = FMT_I;
            case (w_f3)
               3'd0: w_opidx = OP_ADDI;
               3'd1: if (w_f7 == 7'h00) w_opidx = OP_SLLI;
               3'd2: w_opidx = OP_SLTI;
               3'd3: w_opidx = OP_SLTIU;
               3'd4: w_opidx = OP_XORI;
               3'd5: begin
                  if (w_f7 == 7'h00) w_opidx = OP_SRLI;
                  else if (w_f7 == 7'h20) w_opidx = OP_SRAI;
               end
               3'd6:    w_opidx = OP_ORI;
               default: w_opidx = OP_ANDI;
            endcase
         end
         7'b0000011: begin
            w_fmt = FMT_I;
            case (w_f3)
               3'd0:    w_opidx = OP_LB;
               3'd1:    w_opidx = OP_LH;
               3'd2:    w_opidx = OP_LW;
               3'd4:    w_opidx = OP_LBU;
               3'd5:    w_opidx = OP_LHU;
               default: ;
            endcase
         end
         7'b1100111: begin
            w_fmt = FMT_I;
            if (w_f3 == 3'd0) w_opidx = OP_JALR;
         end
         7'b0100011: begin
            w_fmt = FMT_S;
            case (w_f3)
               3'd0:    w_opidx = OP_SB;
               3'd1:    w_opidx = OP_SH;
               3'd2:    w_opidx = OP_SW;
               default: ;
            endcase
         end
         7'b1100011: begin
            w_fmt = FMT_B;
            case (w_f3)
               3'd0:    w_opidx = OP_BEQ;
               3'd1:    w_opidx = OP_BNE;
               3'd4:    w_opidx = OP_BLT;
               3'd5:    w_opidx = OP_BGE;
               3'd6:    w_opidx = OP_BLTU;
               3'd7:    w_opidx = OP_BGEU;
               default: ;
            endcase
         end
         7'b0110111: begin
            w_fmt   = FMT_U;
            w_opidx = OP_LUI;
         end
         7'b0010111: begin
            w_fmt   = FMT_U;
            w_opidx = OP_AUIPC;
         end
         7'b1101111: begin
            w_fmt   = FMT_J;
            w_opidx = OP_JAL;
         end
         default: ;
      endcase
   end

   assign w_legal = (w_opidx < OPW6);

   // Raw 32-bit immediate per format; widened to XLEN by sign extension below.
   always_comb begin
      w_imm32 = 32'd0;
      case (w_fmt)
         FMT_I:   w_imm32 = {{20{instr[31]}}, instr[31:20]};
         FMT_S:   w_imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         FMT_B:   w_imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         FMT_U:   w_imm32 = {instr[31:12], 12'd0};
         FMT_J:   w_imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         default: w_imm32 = 32'd0;
      endcase
   end

   always_comb begin
      w_dec           = '0;
      w_dec.pc        = pc_in;
      w_dec.rd        = instr[11:7];
      w_dec.rs1       = instr[19:15];
      w_dec.rs2       = instr[24:20];
      w_dec.illegal   = !w_legal;
      w_dec.op        = w_legal ? (OP_ONE << w_opidx) : '0;
      w_dec.rd_valid  = w_legal && (w_fmt inside {FMT_R, FMT_I, FMT_U, FMT_J});
      w_dec.rs1_valid = w_legal && (w_fmt inside {FMT_R, FMT_I, FMT_S, FMT_B});
      w_dec.rs2_valid = w_legal && (w_fmt inside {FMT_R, FMT_S, FMT_B});
      w_dec.imm_valid = w_legal && (w_fmt != FMT_R);
      w_dec.imm       = (w_legal && (w_fmt != FMT_R)) ? XLEN'(signed'(w_imm32)) : '0;
   end

   // Skid buffer: r_head is always the presented entry, r_tail the one behind it.
   logic [1:0] r_cnt;
   entry_t     r_head;
   entry_t     r_tail;
   logic       w_push;
   logic       w_pop;

   // in_ready is forced low while reset is asserted, and rises as soon as it releases.
   assign in_ready  = rst_n && (r_cnt != 2'd2);
   assign out_valid = (r_cnt != 2'd0);
   assign w_push    = in_valid && in_ready;
   assign w_pop     = out_valid && out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt  <= 2'd0;
         r_head <= '0;
         r_tail <= '0;
      end else if (flush) begin
         r_cnt <= 2'd0;
      end else begin
         case ({w_push, w_pop})
            2'b10: begin
               if (r_cnt == 2'd0) r_head <= w_dec;
               else r_tail <= w_dec;
               r_cnt <= r_cnt + 2'd1;
            end
            2'b01: begin
               r_head <= r_tail;
               r_cnt  <= r_cnt - 2'd1;
            end
            // Push and pop together only happens with exactly one entry
            // (push needs room, pop needs an entry), so the new one becomes head.
            2'b11:   r_head <= w_dec;
            default: ;
         endcase
      end
   end

   assign pc_out    = r_head.pc;
   assign rd        = r_head.rd;
   assign rs1       = r_head.rs1;
   assign rs2       = r_head.rs2;
   assign rd_valid  = r_head.rd_valid;
   assign rs1_valid = r_head.rs1_valid;
   assign rs2_valid = r_head.rs2_valid;
   assign imm_valid = r_head.imm_valid;
   assign imm       = r_head.imm;
   assign op        = r_head.op;
   assign illegal   = r_head.illegal;

endmodule

// File: doc/decoder_pipe.md
DECODER_PIPE -- requirements
Module: decoder_pipe

Interface
REQ-001 Parameter XLEN, default 32, meaning width of imm and pc paths; legal values 32 and 64.
REQ-002 Parameter EN_M, default 0, meaning 1 adds RV32M decode, 0 treats M encodings as illegal.
REQ-003 Parameter OPW, fixed to 37+8*EN_M, meaning width of op one-hot bus; not user-overridable.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 in_valid  in  1  upstream instruction present.
REQ-007 in_ready  out  1  block can accept an instruction this cycle.
REQ-008 instr  in  32  raw instruction word.
REQ-009 pc_in  in  XLEN  address of instr.
REQ-010 flush  in  1  discard all buffered instructions.
REQ-011 out_valid  out  1  decoded instruction present on outputs.
REQ-012 out_ready  in  1  downstream accepts decoded instruction.
REQ-013 pc_out  out  XLEN  pc of presented instruction.
REQ-014 rd, rs1, rs2  out  5 each  register indices instr[11:7], [19:15], [24:20].
REQ-015 rd_valid, rs1_valid, rs2_valid, imm_valid  out  1 each  field-use flags.
REQ-016 imm  out  XLEN  sign-extended immediate.
REQ-017 op  out  OPW  one-hot operation code.
REQ-018 illegal  out  1  presented instruction is not a supported encoding.

Function
REQ-019 Decode SHALL be combinational on instr at input; results captured into a 2-entry FIFO (skid buffer), head entry drives all outputs directly from flops.
REQ-020 Accept = in_valid & in_ready; in_ready = (occupancy < 2); occupancy 0..2.
REQ-021 Latency: instruction accepted at edge k into empty buffer SHALL show out_valid=1 in cycle after edge k.
REQ-022 Pop = out_valid & out_ready; simultaneous accept and pop SHALL leave occupancy unchanged and preserve order.
REQ-023 While out_valid=1 and out_ready=0, all outputs SHALL remain stable.
REQ-024 At occupancy 2, in_valid SHALL be ignored (no overwrite); in_ready rises the cycle after a pop.
REQ-025 flush=1 at an edge SHALL empty the buffer, overriding same-cycle accept and pop; out_valid=0 and in_ready=1 next cycle.
REQ-026 Format classes by opcode[6:0]: R 0110011, I 0010011/0000011/1100111, S 0100011, B 1100011, U 0110111/0010111, J 1101111; any other opcode illegal.
REQ-027 rd_valid: R,I,U,J; rs1_valid: R,I,S,B; rs2_valid: R,S,B; imm_valid: all non-R legal classes.
REQ-028 imm: I {instr[31:20]}, S {[31:25],[11:7]}, B {[31],[7],[30:25],[11:8],0}, U {[31:12],12'b0}, J {[31],[19:12],[20],[30:21],0}; all sign-extended from bit 31 to XLEN; R/illegal imm=0.
REQ-029 op bit order: 0-9 add,sub,xor,or,and,sll,srl,sra,slt,sltu; 10-18 addi,xori,ori,andi,slli,srli,srai,slti,sltiu; 19-23 lb,lh,lw,lbu,lhu; 24-26 sb,sh,sw; 27-32 beq,bne,blt,bge,bltu,bgeu; 33 jal; 34 jalr; 35 lui; 36 auipc; if EN_M: 37-44 mul,mulh,mulhsu,mulhu,div,divu,rem,remu (funct7 0x01).
REQ-030 Shift-immediates SHALL check instr[31:25] (0x00 for slli/srli, 0x20 for srai); other values illegal.
REQ-031 Any encoding matching no op bit (bad funct3/funct7, jalr funct3!=0, M with EN_M=0) SHALL set illegal=1, op=0, all *_valid=0.
REQ-032 Legal instruction SHALL set exactly one op bit and illegal=0.

Reset
REQ-033 rst_n low SHALL immediately empty buffer: out_valid=0, in_ready=0 during reset, op=0, imm=0, pc_out=0, illegal=0, all indices and flags 0.
REQ-034 First cycle after rst_n deasserts: in_ready=1; reset mid-transfer SHALL discard buffered contents with no partial output.

Verification
REQ-035 instr 0x00500093 (addi x1,x0,5), out_ready=1 -> next cycle op[10]=1, rd=1, rs1=0, imm=5, rd_valid=1, illegal=0.
REQ-036 instr 0x40208133 (sub x2,x1,x2) -> op[1]=1, rd=2, rs1=1, rs2=2, imm_valid=0; instr 0xFE000EE3 (beq x0,x0,-4) -> op[27]=1, imm=0xFFFFFFFC (XLEN=64: 0xFFFFFFFFFFFFFFFC).
REQ-037 instr 0x022081B3: EN_M=1 -> op[37]=1; EN_M=0 -> illegal=1, op=0.
REQ-038 out_ready=0, push A,B: in_ready=0 after second accept, C held off; raise out_ready -> A then B presented in order, outputs stable while stalled.
REQ-039 Buffer full plus in_valid and flush=1 same cycle -> next cycle out_valid=0, in_ready=1, no entry accepted; rst_n pulsed low mid-stream -> outputs zero asynchronously.
